// File: rtl/ysyx_25060170_sram_resp_pkg.sv
// Shared types and widths for the SRAM responder.
//   state_e         : responder FSM states (Idle=0, Wait=1, Resp=2)
//   AddrW/DataW/MaskW : request bus widths
package ysyx_25060170_sram_resp_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned MaskW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_25060170_sram_resp_if.sv
// Request/response bus between a fetch/load-store initiator and the SRAM responder.
//   master : initiator side (drives req_*, rsp_ready)
//   slave  : responder side (drives req_ready, rsp_valid/rdata/err)
interface ysyx_25060170_sram_resp_if;
  import ysyx_25060170_sram_resp_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [AddrW-1:0] req_addr;
  logic             req_wen;
  logic [DataW-1:0] req_wdata;
  logic [MaskW-1:0] req_wmask;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DataW-1:0] rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/ysyx_25060170_sram_array.sv
// Single-port word array: synchronous byte-masked write, combinational read.
//   clk_i   : clock
//   we_i    : write enable (qualified by wmask_i per lane)
//   idx_i   : word index
//   wdata_i : write data, lane i = bits [8i+7:8i]
//   wmask_i : byte-lane write enables
//   rdata_o : word at idx_i
// Storage is intentionally not reset.
module ysyx_25060170_sram_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IdxW        = $clog2(DEPTH_WORDS)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] idx_i,
  input  logic [31:0]     wdata_i,
  input  logic [3:0]      wmask_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int l = 0; l < 4; l++) begin
        if (wmask_i[l]) mem_q[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ysyx_25060170_sram_resp.sv
// Memory-side responder: accepts one request at a time, waits LATENCY cycles, performs a
// byte-masked write or word read, and holds the response until consumed.
//   clk : clock, all state on rising edge
//   rst : synchronous active-low reset
//   bus : slave side of the request/response bus
module ysyx_25060170_sram_resp
  import ysyx_25060170_sram_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_25060170_sram_resp_if.slave      bus
);

  localparam int unsigned     IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned     CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [AddrW-1:0] Span = AddrW'(4 * DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic             wen_q, wen_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic [MaskW-1:0] wmask_q, wmask_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DataW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic [AddrW-1:0] offset;
  logic             addr_ok;
  logic             access;
  logic [DataW-1:0] arr_rdata;

  // Unsigned subtract: addresses below BASE_ADDR wrap to huge offsets and fail the span test,
  // the explicit >= keeps that intent obvious.
  assign offset  = addr_q - BASE_ADDR;
  assign addr_ok = (addr_q >= BASE_ADDR) && (offset < Span) && (addr_q[1:0] == 2'b00);

  ysyx_25060170_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IdxW       (IdxW)
  ) u_array (
    .clk_i  (clk),
    // Gating with rst keeps a write whose access edge coincides with reset from committing.
    .we_i   (access && wen_q && addr_ok && rst),
    .idx_i  (offset[IdxW+1:2]),
    .wdata_i(wdata_q),
    .wmask_i(wmask_q),
    .rdata_o(arr_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    access      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wen_d   = bus.req_wen;
          wdata_d = bus.req_wdata;
          wmask_d = bus.req_wmask;
          cnt_d   = CntW'(LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          access      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ~addr_ok;
          rsp_rdata_d = (addr_ok && !wen_q) ? arr_rdata : '0;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle) && rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_25060170_sram_resp.sv
// Bench for the SRAM responder: one LATENCY=1 instance for most scenarios and a
// LATENCY=4 instance for the stalled-response case. Expected data comes from a word model.
module tb_ysyx_25060170_sram_resp;

  localparam logic [31:0] Base = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst4;

  ysyx_25060170_sram_resp_if bus1 ();
  ysyx_25060170_sram_resp_if bus4 ();

  ysyx_25060170_sram_resp #(
    .BASE_ADDR  (Base),
    .DEPTH_WORDS(1024),
    .LATENCY    (1)
  ) u_dut1 (
    .clk(clk),
    .rst(rst1),
    .bus(bus1)
  );

  ysyx_25060170_sram_resp #(
    .BASE_ADDR  (Base),
    .DEPTH_WORDS(1024),
    .LATENCY    (4)
  ) u_dut4 (
    .clk(clk),
    .rst(rst4),
    .bus(bus4)
  );

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] model [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_ok(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua >= longint'(Base)) && (ua < longint'(Base) + 4096) && (ua % 4 == 0);
  endfunction

  // One request on the selected instance (0: LATENCY=1, 1: LATENCY=4) with rsp_ready high.
  // lat = edges from the accept edge to the edge after which rsp_valid is seen.
  task automatic txn(input bit sel, input logic [31:0] a, input bit w, input logic [31:0] d,
                     input logic [3:0] m, output logic [31:0] rd, output logic er,
                     output int lat);
    int guard;
    @(negedge clk);
    if (sel) begin
      bus4.req_valid = 1'b1; bus4.req_addr = a; bus4.req_wen = w;
      bus4.req_wdata = d;    bus4.req_wmask = m;
    end else begin
      bus1.req_valid = 1'b1; bus1.req_addr = a; bus1.req_wen = w;
      bus1.req_wdata = d;    bus1.req_wmask = m;
    end
    guard = 0;
    while ((sel ? bus4.req_ready : bus1.req_ready) !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (sel) bus4.req_valid = 1'b0;
    else     bus1.req_valid = 1'b0;
    lat = 0;
    while ((sel ? bus4.rsp_valid : bus1.rsp_valid) !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd = sel ? bus4.rsp_rdata : bus1.rsp_rdata;
    er = sel ? bus4.rsp_err : bus1.rsp_err;
    @(posedge clk);
  endtask

  // Request on the LATENCY=1 instance, checked against the word model.
  task automatic op(input string tag, input logic [31:0] a, input bit w, input logic [31:0] d,
                    input logic [3:0] m, output logic [31:0] rd);
    logic        er;
    int          lat;
    bit          ok;
    int          idx;
    logic [31:0] exp_rd;
    ok     = ref_ok(a);
    idx    = ok ? (int'((a - Base) / 4) % 16) : 0;
    exp_rd = (ok && !w) ? model[idx] : 32'h0;
    txn(1'b0, a, w, d, m, rd, er, lat);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, {31'b0, er}, {31'b0, !ok});
    if (ok && w) begin
      for (int l = 0; l < 4; l++) if (m[l]) model[idx][8*l +: 8] = d[8*l +: 8];
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] b2b_addr [8];
    logic [31:0] expq [$];
    int          acc_cyc [$];
    int          cyc, sent, got, k, r;
    logic [31:0] a;

    bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.req_wen = 1'b0;
    bus1.req_wdata = '0;   bus1.req_wmask = '0; bus1.rsp_ready = 1'b1;
    bus4.req_valid = 1'b0; bus4.req_addr = '0; bus4.req_wen = 1'b0;
    bus4.req_wdata = '0;   bus4.req_wmask = '0; bus4.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    rst1 = 1'b0;
    rst4 = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, bus1.req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, bus1.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus1.rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, bus1.rsp_err}, 32'd0);
    check("rst4_req_ready", {31'b0, bus4.req_ready}, 32'd0);
    rst1 = 1'b1;
    rst4 = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", {31'b0, bus1.req_ready}, 32'd1);
    check("post_rst4_req_ready", {31'b0, bus4.req_ready}, 32'd1);

    // Fill the modelled window (words 0..15) with known data
    for (int i = 0; i < 16; i++) op("init", Base + 32'(4 * i), 1'b1, $urandom, 4'hF, rd);

    // Full write then read
    op("t1_wr", 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, rd);
    op("t1_rd", 32'h8000_0010, 1'b0, 32'h0, 4'h0, rd);
    check("t1_rd_lit", rd, 32'hDEAD_BEEF);

    // Masked write merges lanes 0 and 2
    op("t2_wr", 32'h8000_0010, 1'b1, 32'h1122_3344, 4'b0101, rd);
    op("t2_rd", 32'h8000_0010, 1'b0, 32'h0, 4'h0, rd);
    check("t2_rd_lit", rd, 32'hDE22_BE44);
    op("t2_nomask", 32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, rd);
    op("t2_nomask_rd", 32'h8000_0010, 1'b0, 32'h0, 4'h0, rd);

    // Range and alignment errors; erroneous writes must not alias into the array
    op("t3_below", 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, rd);
    op("t3_above", 32'h8000_1000, 1'b0, 32'h0, 4'h0, rd);
    op("t3_misal", 32'h8000_0002, 1'b0, 32'h0, 4'h0, rd);
    op("t3_wr_above", 32'h8000_1000, 1'b1, 32'h5555_5555, 4'hF, rd);
    op("t3_wr_misal", 32'h8000_0012, 1'b1, 32'h6666_6666, 4'hF, rd);
    op("t3_wr_wrap", 32'h0000_0010, 1'b1, 32'h7777_7777, 4'hF, rd);
    op("t3_chk0", 32'h8000_0000, 1'b0, 32'h0, 4'h0, rd);
    op("t3_chk4", 32'h8000_0010, 1'b0, 32'h0, 4'h0, rd);
    txn(1'b0, 32'h8000_0FFC, 1'b1, 32'h5A5A_1234, 4'hF, rd, er, lat);
    check("t3_last_wr_err", {31'b0, er}, 32'd0);
    txn(1'b0, 32'h8000_0FFC, 1'b0, 32'h0, 4'h0, rd, er, lat);
    check("t3_last_rd", rd, 32'h5A5A_1234);
    check("t3_last_rd_err", {31'b0, er}, 32'd0);

    // Reset while a write waits for its access edge
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_addr = 32'h8000_0020; bus1.req_wen = 1'b1;
    bus1.req_wdata = 32'hBAD0_BAD0; bus1.req_wmask = 4'hF;
    check("t5_ready_before", {31'b0, bus1.req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    check("t5_rsp_valid_in_rst", {31'b0, bus1.rsp_valid}, 32'd0);
    check("t5_req_ready_in_rst", {31'b0, bus1.req_ready}, 32'd0);
    rst1 = 1'b1;
    @(negedge clk);
    check("t5_req_ready_after", {31'b0, bus1.req_ready}, 32'd1);
    check("t5_rsp_valid_after", {31'b0, bus1.rsp_valid}, 32'd0);
    op("t5_rd", 32'h8000_0020, 1'b0, 32'h0, 4'h0, rd);

    // Back-to-back reads with req_valid held high
    for (int i = 0; i < 8; i++) b2b_addr[i] = Base + 32'(4 * ((i * 3 + 1) % 16));
    cyc = 0; sent = 0; got = 0;
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_wen = 1'b0; bus1.req_addr = b2b_addr[0];
    while (got < 8 && cyc < 200) begin
      if (bus1.req_valid && bus1.req_ready) begin
        acc_cyc.push_back(cyc);
        expq.push_back(model[int'((bus1.req_addr - Base) / 4) % 16]);
        sent++;
      end
      if (bus1.rsp_valid) begin
        if (expq.size() == 0) begin
          check("t6_extra_rsp", 32'd1, 32'd0);
        end else begin
          check("t6_rdata", bus1.rsp_rdata, expq.pop_front());
          check("t6_err", {31'b0, bus1.rsp_err}, 32'd0);
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (sent >= 8) bus1.req_valid = 1'b0;
      else           bus1.req_addr  = b2b_addr[sent];
      cyc++;
      @(negedge clk);
    end
    check("t6_sent", 32'(sent), 32'd8);
    check("t6_got", 32'(got), 32'd8);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("t6_interval", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    for (int i = 0; i < 4; i++) begin
      check("t6_no_dup", {31'b0, bus1.rsp_valid}, 32'd0);
      @(negedge clk);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = Base + $urandom_range(0, 63);
      else if (r == 7) a = Base - $urandom_range(1, 16);
      else if (r == 8) a = Base + 32'h1000 + $urandom_range(0, 63);
      else             a = 32'h0000_0010 + 32'(4 * $urandom_range(0, 3));
      op("rand", a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), rd);
    end

    // LATENCY=4 with a stalled response
    txn(1'b1, 32'h8000_0040, 1'b1, 32'hCAFE_F00D, 4'hF, rd, er, lat);
    check("t4_wr_lat", 32'(lat), 32'd4);
    check("t4_wr_err", {31'b0, er}, 32'd0);
    @(negedge clk);
    bus4.rsp_ready = 1'b0;
    bus4.req_valid = 1'b1; bus4.req_addr = 32'h8000_0040; bus4.req_wen = 1'b0;
    check("t4_ready_idle", {31'b0, bus4.req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus4.req_valid = 1'b0;
    k = 0;
    while (bus4.rsp_valid !== 1'b1 && k < 20) begin
      check("t4_ready_busy", {31'b0, bus4.req_ready}, 32'd0);
      @(negedge clk);
      k++;
    end
    check("t4_rd_lat", 32'(k), 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_valid", {31'b0, bus4.rsp_valid}, 32'd1);
      check("t4_stall_rdata", bus4.rsp_rdata, 32'hCAFE_F00D);
      check("t4_stall_err", {31'b0, bus4.rsp_err}, 32'd0);
      check("t4_stall_ready", {31'b0, bus4.req_ready}, 32'd0);
      @(negedge clk);
    end
    bus4.rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_rsp_done", {31'b0, bus4.rsp_valid}, 32'd0);
    check("t4_ready_back", {31'b0, bus4.req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
